// File: rtl/deserializer_if.sv
// deserializer_if
// Bundles the codec-side receive pins and the parallel frame output of the
// ADC deserializer into one interface.
//   WIDTH       : bits per channel sample (frame word is 2*WIDTH bits)
//   ADCLRCK     : channel select from codec, high = left, low = right
//   ADCDAT_SER  : serial sample data, MSB first
//   ERR_CLR     : synchronous clear of FRAME_ERR
//   ADCDAT_PAR  : last complete frame {left, right}
//   VALID       : one-cycle pulse when ADCDAT_PAR updates
//   FRAME_ERR   : sticky short-channel flag
// Modports: master = codec/stimulus side, slave = deserializer.
interface deserializer_if #(
  parameter int WIDTH = 16
);
  logic                 ADCLRCK;
  logic                 ADCDAT_SER;
  logic                 ERR_CLR;
  logic [2*WIDTH-1:0]   ADCDAT_PAR;
  logic                 VALID;
  logic                 FRAME_ERR;

  modport master (
    output ADCLRCK, ADCDAT_SER, ERR_CLR,
    input  ADCDAT_PAR, VALID, FRAME_ERR
  );

  modport slave (
    input  ADCLRCK, ADCDAT_SER, ERR_CLR,
    output ADCDAT_PAR, VALID, FRAME_ERR
  );
endinterface

// File: rtl/deserializer.sv
// deserializer
// Captures the codec's serial ADC stream (codec is LRCK/BCLK master) and
// presents one stereo frame per LRCK period as a parallel word
// {left, right}, with a one-cycle VALID pulse on update.
// Ports:
//   BCLK   : bit clock, only clock, posedge logic
//   RST_N  : asynchronous active-low reset
//   bus    : deserializer_if.slave (ADCLRCK, ADCDAT_SER, ERR_CLR in;
//            ADCDAT_PAR, VALID, FRAME_ERR out)
// Build option:
//   DESER_I2S_DELAY_EN defined   -> I2S format, MSB one BCLK after the LRCK
//                                   edge (SKIP state present)
//   DESER_I2S_DELAY_EN undefined -> left-justified, MSB on the edge cycle
module deserializer #(
  parameter int WIDTH = 16
) (
  input  logic          BCLK,
  input  logic          RST_N,
  deserializer_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {
    SYNC    = 3'd0,
    SHIFT_L = 3'd1,
    WAIT_L  = 3'd2,
    SHIFT_R = 3'd3,
    WAIT_R  = 3'd4
`ifdef DESER_I2S_DELAY_EN
    , SKIP  = 3'd5
`endif
  } state_t;

  state_t               state;
  logic                 primed;
  logic                 lrck_q;
  logic [CW-1:0]        bit_cnt;
  // Shift registers hold only the WIDTH-1 older bits; the newest bit is
  // always taken straight from the pin when a sample completes.
  logic [WIDTH-2:0]     left_shift;
  logic [WIDTH-2:0]     right_shift;
  logic [WIDTH-1:0]     left_reg;
  logic [2*WIDTH-1:0]   par_q;
  logic                 valid_q;
  logic                 err_q;
`ifdef DESER_I2S_DELAY_EN
  logic                 skip_to_right;
`endif

  logic                 lrck_edge;
  logic                 lrck_rise;
  logic                 lrck_fall;
  logic                 short_chan;
  logic                 last_bit;
  logic [WIDTH-1:0]     left_next;
  logic [WIDTH-1:0]     right_next;

  // Edge detection is suppressed on the priming cycle so that the level
  // present at reset release is never mistaken for a transition.
  // A short channel is any edge that arrives while a sample is still being
  // gathered, or an edge of the wrong polarity while waiting.
  always_comb begin
    lrck_edge  = primed & (bus.ADCLRCK ^ lrck_q);
    lrck_rise  = lrck_edge & bus.ADCLRCK;
    lrck_fall  = lrck_edge & ~bus.ADCLRCK;
    last_bit   = (bit_cnt == CW'(WIDTH - 1));
    left_next  = {left_shift, bus.ADCDAT_SER};
    right_next = {right_shift, bus.ADCDAT_SER};
    short_chan = lrck_edge
               & (state != SYNC)
               & ~((state == WAIT_L) & lrck_fall)
               & ~((state == WAIT_R) & lrck_rise);
  end

  // Single FSM. A rising edge always (re)starts a left capture, whatever
  // state we are in; a falling edge starts the right channel only from
  // WAIT_L and otherwise drops back to SYNC.
  always_ff @(posedge BCLK or negedge RST_N) begin
    if (!RST_N) begin
      state       <= SYNC;
      primed      <= 1'b0;
      lrck_q      <= 1'b0;
      bit_cnt     <= '0;
      left_shift  <= '0;
      right_shift <= '0;
      left_reg    <= '0;
      par_q       <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
`ifdef DESER_I2S_DELAY_EN
      skip_to_right <= 1'b0;
`endif
    end else begin
      primed  <= 1'b1;
      lrck_q  <= bus.ADCLRCK;
      valid_q <= 1'b0;

      if (short_chan)
        err_q <= 1'b1;
      else if (bus.ERR_CLR)
        err_q <= 1'b0;

      if (lrck_rise) begin
`ifdef DESER_I2S_DELAY_EN
        state         <= SKIP;
        skip_to_right <= 1'b0;
        bit_cnt       <= '0;
`else
        left_shift <= left_next[WIDTH-2:0];
        bit_cnt    <= CW'(1);
        state      <= SHIFT_L;
`endif
      end else if (lrck_fall && state == WAIT_L) begin
`ifdef DESER_I2S_DELAY_EN
        state         <= SKIP;
        skip_to_right <= 1'b1;
        bit_cnt       <= '0;
`else
        right_shift <= right_next[WIDTH-2:0];
        bit_cnt     <= CW'(1);
        state       <= SHIFT_R;
`endif
      end else if (lrck_fall) begin
        state   <= SYNC;
        bit_cnt <= '0;
      end else begin
        case (state)
`ifdef DESER_I2S_DELAY_EN
          SKIP: state <= skip_to_right ? SHIFT_R : SHIFT_L;
`endif
          SHIFT_L: begin
            left_shift <= left_next[WIDTH-2:0];
            if (last_bit) begin
              left_reg <= left_next;
              bit_cnt  <= '0;
              state    <= WAIT_L;
            end else begin
              bit_cnt <= bit_cnt + CW'(1);
            end
          end
          SHIFT_R: begin
            right_shift <= right_next[WIDTH-2:0];
            if (last_bit) begin
              par_q   <= {left_reg, right_next};
              valid_q <= 1'b1;
              bit_cnt <= '0;
              state   <= WAIT_R;
            end else begin
              bit_cnt <= bit_cnt + CW'(1);
            end
          end
          SYNC, WAIT_L, WAIT_R: ;
          default: state <= SYNC;
        endcase
      end
    end
  end

  assign bus.ADCDAT_PAR = par_q;
  assign bus.VALID      = valid_q;
  assign bus.FRAME_ERR  = err_q;

endmodule
